// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: double-buffered hex digits with leading-zero
// blanking, per-digit blink and per-slot brightness duty, all outputs registered.
module seven_seg_scan #(
  parameter int DIGITS     = 4,
  parameter int DWELL      = 12500,
  parameter int BRIGHT_W   = 4,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);
  localparam int CNT_W = $clog2(DWELL);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = BLINK_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [4*DIGITS-1:0] active_data_q, active_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_end;
  logic                frame_wrap;
  logic                blink_phase;
  logic                duty_on;
  logic                cur_lit;
  logic [3:0]          cur_nib;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS:1]     upper_zero;
  logic [DIGITS-1:0]   digit_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  assign blink_phase        = frame_cnt_q[FRM_W-1];
  assign upper_zero[DIGITS] = 1'b1;

  // upper_zero[i] is set when nibbles i..DIGITS-1 are all zero; digit 0 never blanks on it.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi] = active_data_q[4*gi +: 4];
      if (gi == 0) begin : g_first
        assign digit_blank[gi] = blink_phase && blink_en[gi];
      end else begin : g_rest
        if (gi < DIGITS - 1) begin : g_chain
          assign upper_zero[gi] = (nib[gi] == 4'h0) && upper_zero[gi+1];
        end else begin : g_top
          assign upper_zero[gi] = (nib[gi] == 4'h0);
        end
        assign digit_blank[gi] = (blank_lz && upper_zero[gi]) || (blink_phase && blink_en[gi]);
      end
    end
  endgenerate

  always_comb begin
    slot_end   = (cnt_q == CNT_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);

    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_cnt_d  = frame_wrap ? frame_cnt_q + 1'b1 : frame_cnt_q;
    frame_done_d = frame_wrap;

    // The active copy takes the shadow value held before this cycle's load.
    shadow_data_d = load ? data_in : shadow_data_q;
    shadow_dp_d   = load ? dp_in : shadow_dp_q;
    active_data_d = frame_wrap ? shadow_data_q : active_data_q;
    active_dp_d   = frame_wrap ? shadow_dp_q : active_dp_q;

    duty_on = (&bright) || (cnt_q[BRIGHT_W-1:0] < bright);
    cur_nib = nib[idx_q];
    cur_lit = duty_on && !digit_blank[idx_q];

    seg_d = cur_lit ? ~hex_to_seg(cur_nib) : 7'h7F;
    dp_d  = cur_lit ? ~active_dp_q[idx_q] : 1'b1;
    an_d  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = !(cur_lit && (idx_q == IDX_W'(i)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: a scan-position reference model queues the expected output
// of every clock; a negedge monitor drains and compares; directed spot checks run alongside.
`timescale 1ns/1ps
module tb_seven_seg_scan;
  localparam int D     = 4;
  localparam int DW    = 16;
  localparam int BW    = 2;
  localparam int BL    = 1;
  localparam int FRAME = D * DW;

  logic          clk;
  logic          rst;
  logic [4*D-1:0] data_in;
  logic [D-1:0]  dp_in;
  logic          load;
  logic          blank_lz;
  logic [D-1:0]  blink_en;
  logic [BW-1:0] bright;
  logic [6:0]    seg;
  logic          dp;
  logic [D-1:0]  an;
  logic          frame_done;

  int vectors     = 0;
  int miscompares = 0;
  logic [12:0] sb[$];

  seven_seg_scan #(.DIGITS(D), .DWELL(DW), .BRIGHT_W(BW), .BLINK_LOG2(BL)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .bright(bright),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  // Reference model: the scan position since reset fixes slot, digit and frame directly.
  int            pos;
  int            m_c, m_d, m_f;
  logic [4*D-1:0] m_shadow, m_active;
  logic [D-1:0]  m_sdp, m_adp, m_an;
  logic [3:0]    m_nib;
  logic [6:0]    m_seg;
  logic          m_dpo, m_zero, m_lit, m_wrap;

  initial begin
    pos = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pos = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
      end else begin
        m_c   = pos % DW;
        m_d   = (pos / DW) % D;
        m_f   = pos / FRAME;
        m_nib = m_active[4*m_d +: 4];
        m_zero = 1'b1;
        for (int j = m_d; j < D; j++) begin
          if (m_active[4*j +: 4] != 4'h0) m_zero = 1'b0;
        end
        m_lit = ((bright == {BW{1'b1}}) || ((m_c % (1 << BW)) < int'(bright)))
                && !(blank_lz && (m_d > 0) && m_zero)
                && !((((m_f >> BL) % 2) == 1) && blink_en[m_d]);
        m_seg  = m_lit ? ~hex7(m_nib) : 7'h7F;
        m_dpo  = m_lit ? ~m_adp[m_d] : 1'b1;
        m_an   = m_lit ? ~(D'(1) << m_d) : '1;
        m_wrap = ((pos % FRAME) == FRAME - 1);
        sb.push_back({m_seg, m_dpo, m_an, m_wrap});
        if (m_wrap) begin
          m_active = m_shadow;
          m_adp    = m_sdp;
        end
        if (load) begin
          m_shadow = data_in;
          m_sdp    = dp_in;
        end
        pos++;
      end
    end
  end

  // Monitor: one queued expectation per clock, checked on the falling edge.
  initial begin
    logic [12:0] e, g;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = {seg, dp, an, frame_done};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL scan: got seg=%h dp=%b an=%b fd=%b, want seg=%h dp=%b an=%b fd=%b",
                   g[12:6], g[5], g[4:1], g[0], e[12:6], e[5], e[4:1], e[0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [6:0] s, input logic d, input logic [D-1:0] a);
    vectors++;
    if (seg !== s || dp !== d || an !== a) begin
      miscompares++;
      $display("FAIL %s: got seg=%h dp=%b an=%b, want seg=%h dp=%b an=%b", name, seg, dp, an, s, d, a);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic do_load(input logic [4*D-1:0] d, input logic [D-1:0] p);
    @(negedge clk);
    data_in = d; dp_in = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd();
    int n = 0;
    while (frame_done !== 1'b1 && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * FRAME) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_frame_done: got no pulse in %0d cycles, want one", n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic count_lit(output int n);
    n = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (an !== 4'hF) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1 ms, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
    blank_lz = 1'b0; blink_en = '0; bright = 2'd3;
    repeat (3) @(negedge clk);
    check("reset_state", 7'h7F, 1'b1, 4'hF);
    check_int("reset_fd", int'(frame_done), 0);
    rst = 1'b0;
    @(negedge clk);
    check("release_digit0", 7'h40, 1'b1, 4'b1110);

    // Basic display with decimal point on digit 0.
    repeat (4) @(negedge clk);
    do_load(16'h1234, 4'b0001);
    wait_fd();
    @(negedge clk);
    check("d0_1234", 7'h19, 1'b0, 4'b1110);
    repeat (48) @(negedge clk);
    check("d3_1234", 7'h79, 1'b1, 4'b0111);

    // Mid-frame load must not disturb the current frame.
    do_load(16'hABCD, 4'b0000);
    check("hold_prior", 7'h79, 1'b1, 4'b0111);
    wait_fd();
    @(negedge clk);
    check("d0_abcd", 7'h21, 1'b1, 4'b1110);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_fd();
    @(negedge clk);
    check("lz_d0", 7'h40, 1'b1, 4'b1110);
    repeat (16) @(negedge clk);
    check("lz_d1", 7'h12, 1'b1, 4'b1101);
    repeat (16) @(negedge clk);
    check("lz_d2", 7'h7F, 1'b1, 4'b1111);
    repeat (16) @(negedge clk);
    check("lz_d3", 7'h7F, 1'b1, 4'b1111);

    // Brightness duty.
    blank_lz = 1'b0;
    bright = 2'd1;
    wait_fd();
    count_lit(n);
    check_int("bright1_lit_cycles", n, 16);
    bright = 2'd0;
    wait_fd();
    count_lit(n);
    check_int("bright0_lit_cycles", n, 0);
    bright = 2'd3;

    // Blink from a known frame number.
    blink_en = 4'b0010;
    do_reset();
    @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      check("blink_d0", 7'h40, 1'b1, 4'b1110);
      repeat (16) @(negedge clk);
      if (f < 2) check("blink_d1_lit", 7'h40, 1'b1, 4'b1101);
      else       check("blink_d1_dark", 7'h7F, 1'b1, 4'b1111);
      repeat (48) @(negedge clk);
    end
    blink_en = '0;

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      load    = ($urandom_range(0, 15) == 0);
      data_in = 16'($urandom);
      dp_in   = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 63) == 0) blink_en = 4'($urandom);
      if ($urandom_range(0, 63) == 0) bright   = 2'($urandom);
    end
    @(negedge clk);
    load = 1'b0; blank_lz = 1'b0; blink_en = '0; bright = 2'd3;

    // Asynchronous reset at idx=2, cnt=7 of frame 1; a load during reset is ignored.
    @(negedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    data_in = 16'h8888; load = 1'b1;
    repeat (2) @(negedge clk);
    data_in = 16'hFFFF; dp_in = 4'hF; rst = 1'b0;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (102) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_rst", 7'h7F, 1'b1, 4'hF);
    check_int("async_rst_fd", int'(frame_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_d0", 7'h40, 1'b1, 4'b1110);
    repeat (2 * FRAME) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
